relu_hidden_buffer: RTL
=======================

Name: relu_hidden_buffer

Overview:
- Sits directly downstream of the first-stage quadrant MAC.
- Captures each 16-bit z_element pulsed out by that stage and applies ReLU (negative values become 0).
- Stores one full hidden-layer vector of DEPTH elements.
- Then streams the vector out, with a valid/accept handshake, as the a-operand stream for the second stage. The final element is marked with last_element.

Parameters:
- DATA_W, 16, element width (signed two's complement).
- DEPTH, 16, elements per hidden vector; power of two, at least 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).
- CLAMP_MAX, 16'sd4095, upper clamp value; used only when RELU_CLAMP_EN is defined.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- z_element  in  DATA_W  signed dot-product result from the upstream stage.
- z_element_ready  in  1  one-cycle strobe; z_element is valid in that cycle.
- a_element  out  DATA_W  activated element presented to the second stage.
- a_element_ready  out  1  a_element is valid (valid half of the handshake).
- a_element_accept  in  1  second stage consumes a_element this cycle (ready half).
- last_element  out  1  high together with a_element_ready on element DEPTH-1.
- buffer_full  out  1  one-cycle pulse on the cycle the FILL→DRAIN transition is taken.
- overflow  out  1  sticky flag: a z strobe was dropped during DRAIN.
- fill_count  out  ADDR_W+1  number of elements currently stored, 0..DEPTH.

Behaviour:
- Reset (clear high, asynchronous): state=FILL; wr_ptr=0; rd_ptr=0; fill_count=0; a_element=0; a_element_ready=0; last_element=0; buffer_full=0; overflow=0. Buffer contents are don't-care.
- Clear asserted mid-operation aborts any fill or drain immediately. The partial vector is discarded.
- Activation:
  - act = (z_element < 0) ? 0 : z_element.
  - Signed compare on the MSB; pure combinational, no rounding.
- FILL state:
  - When z_element_ready=1: mem[wr_ptr] <= act; wr_ptr++; fill_count++.
  - When this write stores element DEPTH-1:
    - next state = DRAIN;
    - wr_ptr wraps to 0;
    - fill_count becomes DEPTH;
    - buffer_full pulses high for exactly that one cycle (registered, visible the cycle after the strobe).
  - a_element_ready stays 0 throughout FILL.
- DRAIN state:
  - The first cycle in DRAIN loads a_element=mem[0] and sets a_element_ready=1. First valid output therefore appears 2 cycles after the final z strobe.
  - Output is held stable while a_element_ready=1 and a_element_accept=0.
  - On accept of a non-final element: rd_ptr++; fill_count--; the next element is presented the following cycle with no bubble (back-to-back accepts give one element per cycle).
  - last_element=1 exactly when rd_ptr=DEPTH-1 and a_element_ready=1.
  - On accept of the final element: next cycle a_element_ready=0, last_element=0, rd_ptr=0, fill_count=0, state=FILL.
  - Any z_element_ready seen while in DRAIN, including the final-accept cycle, is dropped and sets overflow=1. overflow clears only on reset.
- a_element_accept while a_element_ready=0 is ignored.
- fill_count is never negative and never exceeds DEPTH.

Optional Feature:
- Macro: RELU_CLAMP_EN.
- Defined: act = (z<0) ? 0 : ((z>CLAMP_MAX) ? CLAMP_MAX : z). This is a saturating bounded ReLU; storage and timing are unchanged.
- Undefined: plain ReLU as above; CLAMP_MAX is unused and no comparator is built.

Test Plan:
- Reset then idle: no strobes for 20 cycles → a_element_ready=0, fill_count=0, overflow=0, buffer_full never pulses.
- DEPTH=16: strobe z=0,1,..,15 on consecutive cycles with a_element_accept held 1 → buffer_full pulses once. Outputs are 0..15 on 16 consecutive cycles. last_element is high only with value 15. State then returns to FILL.
- Negative inputs: strobes -5, 7, -32768, 32767, … → outputs 0, 7, 0, 32767 (with RELU_CLAMP_EN and CLAMP_MAX=4095: 0, 7, 0, 4095).
- Backpressure: during DRAIN, hold a_element_accept=0 for 5 cycles with element 3 presented → a_element stays 3 and rd_ptr/fill_count are unchanged. Release → element 4 appears the next cycle.
- Overflow: strobe z=9 during DRAIN → overflow=1 and the drained vector is unchanged. overflow stays 1 after the next full fill/drain and clears only on clear.
- Async reset mid-drain: assert clear between clock edges at element 6 → outputs go to 0 immediately, with no clock edge needed. After release, a fresh 16-element fill drains correctly starting from element 0.

Source files
------------

// File: rtl/relu_hidden_buffer.sv
// Captures one hidden vector of ReLU-activated MAC results, then streams it out with valid/accept.
// Define RELU_CLAMP_EN to build a bounded ReLU that saturates at CLAMP_MAX.
//
// state | meaning
// FILL  | storing activated z strobes into mem; no output valid
// DRAIN | presenting mem[0..DEPTH-1] on a_element; z strobes dropped (overflow)
module relu_hidden_buffer #(
  parameter int                        DATA_W    = 16,
  parameter int                        DEPTH     = 16,
  parameter int                        ADDR_W    = 4,
  parameter logic signed [DATA_W-1:0]  CLAMP_MAX = 16'sd4095
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] z_element,
  input  logic              z_element_ready,
  output logic [DATA_W-1:0] a_element,
  output logic              a_element_ready,
  input  logic              a_element_accept,
  output logic              last_element,
  output logic              buffer_full,
  output logic              overflow,
  output logic [ADDR_W:0]   fill_count
);

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     fill_count_q, fill_count_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic                a_valid_q, a_valid_d;
  logic                buffer_full_q, buffer_full_d;
  logic                overflow_q, overflow_d;
  logic                mem_we;
  logic [DATA_W-1:0]   act;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    act = z_element;
    if (z_element[DATA_W-1]) begin
      act = '0;
    end
`ifdef RELU_CLAMP_EN
    else if ($signed(z_element) > CLAMP_MAX) begin
      act = CLAMP_MAX;
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fill_count_d  = fill_count_q;
    a_data_d      = a_data_q;
    a_valid_d     = a_valid_q;
    buffer_full_d = 1'b0;
    overflow_d    = overflow_q;
    mem_we        = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (z_element_ready) begin
          mem_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          fill_count_d = fill_count_q + COUNT_ONE;
          if (wr_ptr_q == LAST_IDX) begin
            state_d       = ST_DRAIN;
            buffer_full_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (z_element_ready) begin
          overflow_d = 1'b1;
        end
        // The first DRAIN cycle only loads mem[0]; afterwards each accept advances with no bubble.
        if (!a_valid_q) begin
          a_data_d  = mem_q[rd_ptr_q];
          a_valid_d = 1'b1;
        end else if (a_element_accept) begin
          if (rd_ptr_q == LAST_IDX) begin
            a_valid_d    = 1'b0;
            a_data_d     = '0;
            rd_ptr_d     = '0;
            fill_count_d = '0;
            state_d      = ST_FILL;
          end else begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            fill_count_d = fill_count_q - COUNT_ONE;
            a_data_d     = mem_q[rd_ptr_d];
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q       <= ST_FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_count_q  <= '0;
      a_data_q      <= '0;
      a_valid_q     <= 1'b0;
      buffer_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_count_q  <= fill_count_d;
      a_data_q      <= a_data_d;
      a_valid_q     <= a_valid_d;
      buffer_full_q <= buffer_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage is not reset; contents are only read after a complete fill.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= act;
    end
  end

  assign a_element       = a_data_q;
  assign a_element_ready = a_valid_q;
  assign last_element    = a_valid_q && (rd_ptr_q == LAST_IDX);
  assign buffer_full     = buffer_full_q;
  assign overflow        = overflow_q;
  assign fill_count      = fill_count_q;

endmodule
